// File: rtl/fsm_fed_fifo.sv
// Self-filling buffer: a synchronous FIFO fed by a producer FSM that writes an
// incrementing sequence up to a high-water mark and resumes at a low-water mark.

module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [3:0]            o_count
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  FULL_CNT = 4'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [3:0]            r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Full blocks writes and empty blocks reads, which also resolves the
  // simultaneous read+write corner cases at the boundaries.
  assign w_wr_acc = i_wr_en && !o_full;
  assign w_rd_acc = i_rd_en && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_data   <= r_mem[r_rd_ptr];
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the count gates reads, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == 4'd0);

endmodule

module fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int HIGH_MARK  = 6,
  parameter int LOW_MARK   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            i_words,
  input  logic                  i_full,
  output logic                  o_wr_en,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [3:0]            HI_CNT = 4'(HIGH_MARK);
  localparam logic [3:0]            LO_CNT = 4'(LOW_MARK);
  localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_next;
  end

  // NOTE: defaults assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    case (r_state)
      S_FILL: begin
        w_wr_en = (i_words < HI_CNT);
        if (i_words >= HI_CNT) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_words <= LO_CNT) w_next = S_FILL;
      end
      default: w_next = S_FILL;
    endcase
  end

  // Advances only on accepted writes so the stored stream has no gaps.
  always_ff @(posedge clk) begin
    if (!rst_n)                 r_data <= '0;
    else if (w_wr_en && !i_full) r_data <= r_data + ONE;
  end

  assign o_wr_en = w_wr_en;
  assign o_data  = r_data;

endmodule

module fsm_fed_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int HIGH_MARK  = 6,
  parameter int LOW_MARK   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [3:0]            fifo_words,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data
);

  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [DATA_WIDTH-1:0] w_data_out;
  logic                  w_full;
  logic                  w_empty;
  logic [3:0]            w_words;

  fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .HIGH_MARK  (HIGH_MARK),
    .LOW_MARK   (LOW_MARK)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_words (w_words),
    .i_full  (w_full),
    .o_wr_en (w_wr_en),
    .o_data  (w_fifo_data)
  );

  fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (w_wr_en),
    .i_data  (w_fifo_data),
    .i_rd_en (rd_en),
    .o_data  (w_data_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_words)
  );

  assign data_out   = w_data_out;
  assign full       = w_full;
  assign empty      = w_empty;
  assign fifo_words = w_words;
  assign wr_en      = w_wr_en;
  assign fifo_data  = w_fifo_data;

endmodule

// File: tb/tb_fsm_fed_fifo.sv
// Directed bench for fsm_fed_fifo: data_out is scored against a queue of
// hand-computed expected reads; occupancy and strobes are checked inline.

module tb_fsm_fed_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_en = 1'b0;
  logic       rd_en2 = 1'b0;

  logic [7:0] data_out, fifo_data;
  logic       full, empty, wr_en;
  logic [3:0] fifo_words;

  logic [7:0] data_out2, fifo_data2;
  logic       full2, empty2, wr_en2;
  logic [3:0] fifo_words2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         wr_cycles;

  always #5 clk = ~clk;

  fsm_fed_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .fifo_words (fifo_words),
    .wr_en      (wr_en),
    .fifo_data  (fifo_data)
  );

  fsm_fed_fifo #(.HIGH_MARK(8)) dut_hm8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en2),
    .data_out   (data_out2),
    .full       (full2),
    .empty      (empty2),
    .fifo_words (fifo_words2),
    .wr_en      (wr_en2),
    .fifo_data  (fifo_data2)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every accepted read must match the next queued value.
  always @(posedge clk) begin
    if (rst_n && rd_en && !empty) begin
      #1;
      if (exp_q.size() == 0) check("sb_unexpected_read", 32'(data_out), 32'hFFFF_FFFF);
      else                   check("sb_data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // Reset state
    apply_reset();
    check("rst_words", 32'(fifo_words), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_wr_en", 32'(wr_en), 1);
    check("rst_fifo_data", 32'(fifo_data), 0);
    check("rst_data_out",  32'(data_out), 0);

    // Fill to the high mark with no reads
    wr_cycles = 0;
    for (int i = 1; i <= 10; i++) begin
      if (wr_en === 1'b1) wr_cycles++;
      tick();
      check("fill_words", 32'(fifo_words), (i < 6) ? i : 6);
    end
    check("fill_wr_cycles", wr_cycles, 6);
    check("fill_fifo_data", 32'(fifo_data), 6);
    check("fill_wr_en", 32'(wr_en), 0);
    check("fill_full",  32'(full), 0);
    check("fill_empty", 32'(empty), 0);

    // Single read in HOLD
    exp_q.push_back(8'h00);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd1_words", 32'(fifo_words), 5);
    check("rd1_wr_en", 32'(wr_en), 0);

    // Drain to the low mark, then writes resume
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("low_words", 32'(fifo_words), 2);
    check("low_wr_en_hold", 32'(wr_en), 0);
    tick();
    check("resume_wr_en", 32'(wr_en), 1);
    check("resume_fifo_data", 32'(fifo_data), 8'h06);
    tick();
    check("resume_words", 32'(fifo_words), 3);
    check("resume_fifo_data2", 32'(fifo_data), 8'h07);

    // One-cycle reset mid-fill discards contents
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_words", 32'(fifo_words), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_fifo_data", 32'(fifo_data), 0);
    repeat (3) tick();
    check("refill_words", 32'(fifo_words), 3);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("refill_words_after_rd", 32'(fifo_words), 3);

    // rd_en held high from reset: first read ignored, then steady streaming
    rd_en = 1'b1;
    apply_reset();
    check("stream_rst_data_out", 32'(data_out), 0);
    tick();
    check("stream_ignored_data_out", 32'(data_out), 0);
    check("stream_first_words", 32'(fifo_words), 1);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("stream_words", 32'(fifo_words), 1);
    end
    rd_en = 1'b0;

    // HIGH_MARK = DEPTH instance fills completely and never overflows
    apply_reset();
    repeat (12) tick();
    check("hm8_words", 32'(fifo_words2), 8);
    check("hm8_full",  32'(full2), 1);
    check("hm8_fifo_data", 32'(fifo_data2), 8);
    check("hm8_wr_en", 32'(wr_en2), 0);
    tick();
    check("hm8_words_hold", 32'(fifo_words2), 8);
    rd_en2 = 1'b1;
    tick();
    rd_en2 = 1'b0;
    check("hm8_rd_data_out", 32'(data_out2), 0);
    check("hm8_rd_words", 32'(fifo_words2), 7);
    check("hm8_rd_full",  32'(full2), 0);
    check("hm8_rd_wr_en", 32'(wr_en2), 0);

    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
